// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational off the registered table; execute trains it via the update port.
module branch_target_buffer #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  input  logic [3:0]  f_traits,
  input  logic [25:0] f_jindex,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic [3:0]  u_traits,
  input  logic        u_taken,
  input  logic [31:0] u_target,
  input  logic        u_pred_taken,
  input  logic [31:0] u_pred_target,
  output logic        u_mispredict,
  output logic [31:0] n_update,
  output logic [31:0] n_mispredict
);
  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [29:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [31:0]           n_update_q, n_update_d;
  logic [31:0]           n_mispredict_q, n_mispredict_d;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic [31:0]           f_pc4;
  logic                  f_match, u_hit;
  logic                  ent_we;
  logic [1:0]            ent_ctr_d;
  logic [29:0]           ent_target_d;
  logic                  unused_u_bits;

  assign f_idx = f_pc[INDEX_BITS+1:2];
  assign f_tag = f_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign u_idx = u_pc[INDEX_BITS+1:2];
  assign u_tag = u_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign f_pc4 = f_pc + 32'd4;

  assign f_match = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign unused_u_bits = ^{u_pc[31:INDEX_BITS+TAG_BITS+2], u_pc[1:0], u_traits[1:0]};

  // jr and branch share the table path, so priority only matters between table and jump paths
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = f_pc4;
    if (f_traits[3] || f_traits[2]) begin
      pred_hit   = f_match;
      pred_taken = f_match && ctr_q[f_idx][1];
      if (pred_taken) pred_target = {target_q[f_idx], 2'b00};
    end else if (f_traits[1] || f_traits[0]) begin
      pred_taken  = 1'b1;
      pred_target = {f_pc4[31:28], f_jindex, 2'b00};
    end
  end

  always_comb begin
    ent_we       = 1'b0;
    ent_ctr_d    = ctr_q[u_idx];
    ent_target_d = target_q[u_idx];
    if (u_valid && (u_traits[3] || u_traits[2])) begin
      if (u_hit) begin
        ent_we = 1'b1;
        if (u_taken) begin
          ent_ctr_d    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          ent_target_d = u_target[31:2];
        end else begin
          ent_ctr_d = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (u_taken) begin
        ent_we       = 1'b1;
        ent_ctr_d    = 2'b10;
        ent_target_d = u_target[31:2];
      end
    end
  end

  assign u_mispredict = u_valid &&
                        ((u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target)));

  always_comb begin
    n_update_d     = n_update_q;
    n_mispredict_d = n_mispredict_q;
    if (u_valid) n_update_d = n_update_q + 32'd1;
    if (u_mispredict) n_mispredict_d = n_mispredict_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
      n_update_q     <= '0;
      n_mispredict_q <= '0;
    end else begin
      if (ent_we) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= ent_target_d;
        ctr_q[u_idx]    <= ent_ctr_d;
      end
      n_update_q     <= n_update_d;
      n_mispredict_q <= n_mispredict_d;
    end
  end

  assign n_update     = n_update_q;
  assign n_mispredict = n_mispredict_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, reset corner case,
// then randomized traffic against an array-based reference model.
module tb_branch_target_buffer;
  localparam int unsigned IB = 4;
  localparam int unsigned TB = 8;
  localparam int unsigned NE = 2 ** IB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic [3:0]  f_traits;
  logic [25:0] f_jindex;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        u_valid;
  logic [31:0] u_pc;
  logic [3:0]  u_traits;
  logic        u_taken;
  logic [31:0] u_target;
  logic        u_pred_taken;
  logic [31:0] u_pred_target;
  logic        u_mispredict;
  logic [31:0] n_update, n_mispredict;

  int checks = 0;
  int failures = 0;

  branch_target_buffer #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
    .clk(clk), .reset(reset),
    .f_pc(f_pc), .f_traits(f_traits), .f_jindex(f_jindex),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .u_valid(u_valid), .u_pc(u_pc), .u_traits(u_traits), .u_taken(u_taken),
    .u_target(u_target), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .u_mispredict(u_mispredict), .n_update(n_update), .n_mispredict(n_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fpc;  logic [3:0] ftr;  logic [25:0] fji;
    logic uv; logic [31:0] upc; logic [3:0] utr; logic utk;
    logic [31:0] utgt; logic uptk; logic [31:0] uptgt;
    logic ehit; logic etk; logic [31:0] etgt; logic emisp;
    logic [31:0] enu; logic [31:0] enm;
  } vec_t;
  vec_t vq[$];

  // reference table: full word-aligned targets, integer counters
  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  logic [31:0] m_nu, m_nm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] fpc, input logic [3:0] ftr, input logic [25:0] fji,
                     input logic uv, input logic [31:0] upc, input logic [3:0] utr,
                     input logic utk, input logic [31:0] utgt, input logic uptk,
                     input logic [31:0] uptgt, input logic ehit, input logic etk,
                     input logic [31:0] etgt, input logic emisp, input logic [31:0] enu,
                     input logic [31:0] enm);
    vec_t v;
    v.fpc = fpc; v.ftr = ftr; v.fji = fji; v.uv = uv; v.upc = upc; v.utr = utr;
    v.utk = utk; v.utgt = utgt; v.uptk = uptk; v.uptgt = uptgt; v.ehit = ehit;
    v.etk = etk; v.etgt = etgt; v.emisp = emisp; v.enu = enu; v.enm = enm;
    vq.push_back(v);
  endtask

  task automatic idle_update();
    u_valid = 1'b0; u_pc = '0; u_traits = '0; u_taken = 1'b0;
    u_target = '0; u_pred_taken = 1'b0; u_pred_target = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_nu = '0; m_nm = '0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, input logic [3:0] tr, input logic [25:0] ji,
                              output logic hit, output logic tk, output logic [31:0] tgt);
    int unsigned idx = (pc / 4) % NE;
    int unsigned tg  = (pc / (4 * NE)) % (2 ** TB);
    hit = 1'b0; tk = 1'b0; tgt = pc + 32'd4;
    if (tr[3] || tr[2]) begin
      hit = m_valid[idx] && (m_tag[idx] == tg);
      tk  = hit && (m_ctr[idx] >= 2);
      if (tk) tgt = m_tgt[idx];
    end else if (tr[1] || tr[0]) begin
      tk  = 1'b1;
      tgt = ((pc + 32'd4) & 32'hF000_0000) + {4'h0, ji, 2'b00};
    end
  endtask

  function automatic logic model_misp();
    return u_valid && ((u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target)));
  endfunction

  task automatic model_update();
    int unsigned idx = (u_pc / 4) % NE;
    int unsigned tg  = (u_pc / (4 * NE)) % (2 ** TB);
    if (u_valid) begin
      m_nu = m_nu + 1;
      if (model_misp()) m_nm = m_nm + 1;
      if (u_traits[3] || u_traits[2]) begin
        if (m_valid[idx] && m_tag[idx] == tg) begin
          if (u_taken) begin
            m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            m_tgt[idx] = u_target & 32'hFFFF_FFFC;
          end else begin
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
          end
        end else if (u_taken) begin
          m_valid[idx] = 1'b1; m_tag[idx] = tg; m_ctr[idx] = 2;
          m_tgt[idx] = u_target & 32'hFFFF_FFFC;
        end
      end
    end
  endtask

  localparam logic [31:0] B  = 32'h0040_0010, BT = 32'h0040_0040, B4 = 32'h0040_0014;
  localparam logic [31:0] A  = 32'h0040_0050, AT = 32'h0040_0080, A4 = 32'h0040_0054;
  localparam logic [31:0] J  = 32'h0040_0020;
  localparam logic [3:0]  BR = 4'b0100, JL = 4'b0010;

  initial begin
    logic eh, et;
    logic [31:0] eg;
    reset = 1'b1;
    f_pc = B; f_traits = BR; f_jindex = '0;
    idle_update();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //  f_pc   ftr    fji         uv upc ut  tk utgt          ptk ptgt  hit tk tgt    misp nu nm
    add(B, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, B4, 0, 0, 0);
    add(B, BR, 26'h0, 1, B, BR, 1, BT, 0, B4,                 0, 0, B4, 1, 0, 0);
    add(B, BR, 26'h0, 1, B, BR, 0, 0, 1, BT,                  1, 1, BT, 1, 1, 1);
    add(B, BR, 26'h0, 1, B, BR, 0, 0, 0, B4,                  1, 0, B4, 0, 2, 2);
    add(B, BR, 26'h0, 1, B, BR, 1, BT, 0, B4,                 1, 0, B4, 1, 3, 2);
    add(B, BR, 26'h0, 1, B, BR, 1, BT, 0, B4,                 1, 0, B4, 1, 4, 3);
    add(B, BR, 26'h0, 1, B, BR, 1, BT, 1, BT,                 1, 1, BT, 0, 5, 4);
    add(B, BR, 26'h0, 1, B, BR, 1, BT, 1, BT,                 1, 1, BT, 0, 6, 4);
    add(B, BR, 26'h0, 1, B, BR, 0, 0, 1, BT,                  1, 1, BT, 1, 7, 4);
    add(B, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    1, 1, BT, 0, 8, 5);
    add(A, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, A4, 0, 8, 5);
    add(A, BR, 26'h0, 1, A, BR, 1, AT, 0, A4,                 0, 0, A4, 1, 8, 5);
    add(B, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, B4, 0, 9, 6);
    add(A, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    1, 1, AT, 0, 9, 6);
    add(J, JL, 26'h0100008, 1, J, JL, 1, J, 1, J,             0, 1, J, 0, 9, 6);
    add(J, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 32'h0040_0024, 0, 10, 6);
    add(32'h0040_0100, 4'b0000, 26'h3, 1, 32'h0040_0100, 4'b0000, 0, 0, 0, 0,
        0, 0, 32'h0040_0104, 0, 10, 6);
    add(32'hEFFF_FFFC, 4'b0001, 26'h3FF_FFFF, 0, 0, 0, 0, 0, 0, 0,
        0, 1, 32'hFFFF_FFFC, 0, 11, 6);
    add(A, 4'b1111, 26'h0, 0, 0, 0, 0, 0, 0, 0,               1, 1, AT, 0, 11, 6);
    add(A, BR, 26'h0, 1, A, 4'b1000, 1, AT + 32'h10, 1, AT,   1, 1, AT, 1, 11, 6);
    add(A, BR, 26'h0, 0, 0, 0, 0, 0, 0, 0,                    1, 1, AT + 32'h10, 0, 12, 7);

    foreach (vq[i]) begin
      f_pc = vq[i].fpc; f_traits = vq[i].ftr; f_jindex = vq[i].fji;
      u_valid = vq[i].uv; u_pc = vq[i].upc; u_traits = vq[i].utr; u_taken = vq[i].utk;
      u_target = vq[i].utgt; u_pred_taken = vq[i].uptk; u_pred_target = vq[i].uptgt;
      @(negedge clk);
      check($sformatf("v%0d.hit", i), {31'b0, pred_hit}, {31'b0, vq[i].ehit});
      check($sformatf("v%0d.taken", i), {31'b0, pred_taken}, {31'b0, vq[i].etk});
      check($sformatf("v%0d.target", i), pred_target, vq[i].etgt);
      check($sformatf("v%0d.misp", i), {31'b0, u_mispredict}, {31'b0, vq[i].emisp});
      check($sformatf("v%0d.n_update", i), n_update, vq[i].enu);
      check($sformatf("v%0d.n_misp", i), n_mispredict, vq[i].enm);
      @(posedge clk); #1;
    end

    // reset must win over a concurrent taken update
    u_valid = 1'b1; u_pc = A; u_traits = BR; u_taken = 1'b1; u_target = AT;
    u_pred_taken = 1'b0; u_pred_target = A4;
    f_pc = A; f_traits = BR;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_update();
    @(negedge clk);
    check("rst.hit", {31'b0, pred_hit}, 32'd0);
    check("rst.taken", {31'b0, pred_taken}, 32'd0);
    check("rst.target", pred_target, A4);
    check("rst.n_update", n_update, 32'd0);
    check("rst.n_misp", n_mispredict, 32'd0);
    model_reset();
    @(posedge clk); #1;

    for (int n = 0; n < 600; n++) begin
      u_valid       = ($urandom_range(0, 9) < 8);
      u_pc          = 32'h0040_0000 | ($urandom_range(0, 63) << 2);
      u_traits      = 4'($urandom);
      u_taken       = 1'($urandom);
      u_target      = $urandom;
      u_pred_taken  = 1'($urandom);
      u_pred_target = ($urandom_range(0, 1) == 1) ? u_target : $urandom;
      f_pc          = ($urandom_range(0, 3) == 0) ? u_pc
                                                  : 32'h0040_0000 | ($urandom_range(0, 63) << 2);
      f_traits      = 4'($urandom);
      f_jindex      = 26'($urandom);
      @(negedge clk);
      model_lookup(f_pc, f_traits, f_jindex, eh, et, eg);
      check("rnd.hit", {31'b0, pred_hit}, {31'b0, eh});
      check("rnd.taken", {31'b0, pred_taken}, {31'b0, et});
      check("rnd.target", pred_target, eg);
      check("rnd.misp", {31'b0, u_mispredict}, {31'b0, model_misp()});
      check("rnd.n_update", n_update, m_nu);
      check("rnd.n_misp", n_mispredict, m_nm);
      @(posedge clk);
      model_update();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters. It consumes the `{jr, branch, jal, jmp}` trait vector produced at decode of the fetched instruction and returns a next-PC prediction to fetch in the same cycle. The execute stage writes back the resolved outcome through a separate update port, which trains the table and maintains mispredict statistics.

## Interface
- `INDEX_BITS`, 4: table has 2^INDEX_BITS entries; index = pc[INDEX_BITS+1:2]
- `TAG_BITS`, 8: tag = pc[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2]
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `f_pc`  in  32  fetch PC (word aligned)
- `f_traits`  in  4  fetched-instruction traits {jr, branch, jal, jmp}
- `f_jindex`  in  26  instr[25:0] of fetched instruction
- `pred_hit`  out  1  valid entry with matching tag (branch/jr only)
- `pred_taken`  out  1  predicted redirect
- `pred_target`  out  32  predicted next PC
- `u_valid`  in  1  update strobe from execute
- `u_pc`  in  32  PC of resolved instruction
- `u_traits`  in  4  traits of resolved instruction
- `u_taken`  in  1  actual outcome
- `u_target`  in  32  actual target (meaningful when u_taken)
- `u_pred_taken`, `u_pred_target`  in  1, 32  prediction carried down the pipe
- `u_mispredict`  out  1  combinational mispredict flag for current update
- `n_update`, `n_mispredict`  out  32, 32  statistics counters

## Operation
- Entry: valid, tag[TAG_BITS], target[31:2], ctr[1:0].
- Trait priority when several bits set: jr > branch > jal > jmp.
- Lookup (combinational, reads registered table):
  - jmp or jal: pred_hit=0, pred_taken=1, pred_target={(f_pc+4)[31:28], f_jindex, 2'b00}.
  - branch or jr: pred_hit = valid & tag match; pred_taken = pred_hit & ctr[1]; pred_target = taken ? {target,2'b00} : f_pc+4.
  - no trait: pred_hit=0, pred_taken=0, pred_target=f_pc+4.
- Update (u_valid=1, u_traits has jr or branch; otherwise the table is untouched):
  - hit: u_taken ? ctr=sat_inc(ctr), target=u_target[31:2] : ctr=sat_dec(ctr). ctr saturates at 2'b11 / 2'b00.
  - miss & u_taken: allocate/replace: valid=1, tag, target=u_target[31:2], ctr=2'b10.
  - miss & !u_taken: no change.
- u_mispredict = u_valid & ((u_taken != u_pred_taken) | (u_taken & u_target != u_pred_target)); covers all trait kinds including jal/jmp and no-trait.
- Statistics: on u_valid, n_update += 1; if u_mispredict, n_mispredict += 1; both wrap modulo 2^32.

## Timing
- Lookup: zero latency, pure function of f_* and table state.
- Update written at the rising edge where u_valid=1; visible to lookup from next cycle.
- Same-cycle lookup and update to the same entry: lookup returns pre-update contents.
- Reset (synchronous): all valid=0, ctr=2'b00, target=0, n_update=0, n_mispredict=0; reset overrides a concurrent u_valid. Outputs after reset: pred_hit=0; pred_taken/pred_target follow the lookup rules with an empty table.
- No stalls and no back-pressure; one update per cycle maximum.

## Test plan
- Reset, lookup f_pc=0x00400010 branch -> pred_hit=0, pred_taken=0, pred_target=0x00400014; n_update=0, n_mispredict=0.
- Update u_pc=0x00400010 branch taken, u_target=0x00400040, u_pred_taken=0 -> u_mispredict=1, n_mispredict=1. Next cycle the same lookup gives hit=1, taken=1, target=0x00400040. Two not-taken updates -> ctr=00, taken=0. Three taken updates -> ctr=11. A fourth taken update keeps ctr=11.
- Alias: entry at 0x00400010 valid, lookup 0x00400050 (same index 4, tag 1 vs 0) -> hit=0. Taken update at 0x00400050 replaces the entry; 0x00400010 then misses.
- jal at f_pc=0x00400020, f_jindex=0x0100008 -> pred_taken=1, pred_target=0x00400020, pred_hit=0. Update with matching prediction -> u_mispredict=0 and table unchanged.
- Update and lookup of the same pc in one cycle -> lookup shows old state; the following cycle shows new state.
- Assert reset while u_valid=1 with a taken update -> after the edge, entry invalid and both counters 0.
